// File: rtl/game_timer.sv
// game_timer: elapsed/remaining game-time keeper with BCD display copies.
// Optional TIMER_BLINK_EN adds a 2 Hz blank strobe while the result is frozen.
module game_timer #(
   parameter int CLK_DIV = 100_000_000,
   parameter int LIMIT   = 60,
   parameter int SEC_MAX = 999
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        timer_start,
   input  logic        timer_endn,
   input  logic        countdown_en,
   input  logic        mode,
   output logic [9:0]  sec,
   output logic [9:0]  remain,
   output logic [11:0] disp_bcd,
   output logic        tick,
   output logic        expire,
   output logic        blink
);
   localparam logic [1:0] IDLE = 2'd0, HOLD = 2'd1, RUN = 2'd2;
   localparam int PW = $clog2(CLK_DIV);
   localparam logic [11:0] LIMIT_BCD = {4'(LIMIT / 100), 4'((LIMIT / 10) % 10), 4'(LIMIT % 10)};

   function automatic logic [11:0] bcd_inc(input logic [11:0] v);
      bcd_inc = v;
      if (v[3:0] != 4'd9) bcd_inc[3:0] = v[3:0] + 4'd1;
      else begin
         bcd_inc[3:0] = 4'd0;
         if (v[7:4] != 4'd9) bcd_inc[7:4] = v[7:4] + 4'd1;
         else begin
            bcd_inc[7:4]  = 4'd0;
            bcd_inc[11:8] = v[11:8] + 4'd1;
         end
      end
   endfunction

   function automatic logic [11:0] bcd_dec(input logic [11:0] v);
      bcd_dec = v;
      if (v[3:0] != 4'd0) bcd_dec[3:0] = v[3:0] - 4'd1;
      else begin
         bcd_dec[3:0] = 4'd9;
         if (v[7:4] != 4'd0) bcd_dec[7:4] = v[7:4] - 4'd1;
         else begin
            bcd_dec[7:4]  = 4'd9;
            bcd_dec[11:8] = v[11:8] - 4'd1;
         end
      end
   endfunction

   logic [1:0]    w_next;
   logic          w_tick;
   logic          w_dec;
   logic [PW-1:0] r_pre;
   logic [11:0]   r_sec_bcd;
   logic [11:0]   r_rem_bcd;

   // Actions follow the inputs sampled at each edge; IDLE beats HOLD beats RUN.
   assign w_next   = !timer_start ? IDLE : timer_endn ? HOLD : RUN;
   assign w_tick   = (w_next == RUN) && (r_pre == PW'(CLK_DIV - 1));
   assign w_dec    = countdown_en && (remain != 10'd0);
   assign disp_bcd = mode ? r_rem_bcd : r_sec_bcd;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pre     <= '0;
         sec       <= 10'd0;
         remain    <= 10'(LIMIT);
         r_sec_bcd <= 12'h000;
         r_rem_bcd <= LIMIT_BCD;
         tick      <= 1'b0;
         expire    <= 1'b0;
      end else begin
         tick   <= w_tick;
         expire <= w_tick && w_dec && (remain == 10'd1) && mode;
         if (w_next == IDLE) begin
            r_pre     <= '0;
            sec       <= 10'd0;
            remain    <= 10'(LIMIT);
            r_sec_bcd <= 12'h000;
            r_rem_bcd <= LIMIT_BCD;
         end else if (w_next == RUN) begin
            r_pre <= w_tick ? '0 : r_pre + PW'(1);
            if (w_tick && (sec != 10'(SEC_MAX))) begin
               sec       <= sec + 10'd1;
               r_sec_bcd <= bcd_inc(r_sec_bcd);
            end
            if (w_tick && w_dec) begin
               remain    <= remain - 10'd1;
               r_rem_bcd <= bcd_dec(r_rem_bcd);
            end
         end
      end
   end

`ifdef TIMER_BLINK_EN
   localparam int PH = (CLK_DIV / 4 > 0) ? CLK_DIV / 4 : 1;
   localparam int BW = $clog2(PH > 1 ? PH : 2);
   logic [1:0]    r_state;
   logic [BW-1:0] r_bcnt;

   // Phase counter restarts on every HOLD entry so the flash always opens lit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_bcnt  <= '0;
         blink   <= 1'b1;
      end else begin
         r_state <= w_next;
         if ((w_next != HOLD) || (r_state != HOLD)) begin
            r_bcnt <= '0;
            blink  <= 1'b1;
         end else if (r_bcnt == BW'(PH - 1)) begin
            r_bcnt <= '0;
            blink  <= ~blink;
         end else begin
            r_bcnt <= r_bcnt + BW'(1);
         end
      end
   end
`else
   assign blink = 1'b1;
`endif
endmodule

// File: tb/tb_game_timer.sv
// tb_game_timer: randomized scoreboard bench for game_timer (CLK_DIV=8, LIMIT=3).
module tb_game_timer;
   localparam int CLK_DIV = 8;
   localparam int LIMIT   = 3;
   localparam int SEC_MAX = 999;
   localparam int PH      = CLK_DIV / 4;

   logic clk = 0, rst = 0;
   logic timer_start = 0, timer_endn = 0, countdown_en = 0, mode = 0;
   logic [9:0] sec, remain;
   logic [11:0] disp_bcd;
   logic tick, expire, blink;

   game_timer #(.CLK_DIV(CLK_DIV), .LIMIT(LIMIT), .SEC_MAX(SEC_MAX)) dut (
      .clk(clk), .rst(rst), .timer_start(timer_start), .timer_endn(timer_endn),
      .countdown_en(countdown_en), .mode(mode), .sec(sec), .remain(remain),
      .disp_bcd(disp_bcd), .tick(tick), .expire(expire), .blink(blink)
   );

   always #5 clk = ~clk;

   typedef struct {int s; int r; int t; int e; int b;} exp_t;
   exp_t q[$];
   int checks = 0, errors = 0;
   bit started = 0;

   int m_sec, m_rem, m_pre, m_hk;
   bit m_hold;

   function automatic int to_bcd(int v);
      return (v / 100) * 256 + ((v / 10) % 10) * 16 + v % 10;
   endfunction

   task automatic chk(string n, int act, int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d required %0d at %0t", n, act, req, $time);
      end
   endtask

   function automatic int m_blink();
`ifdef TIMER_BLINK_EN
      return m_hold ? int'(((m_hk / PH) % 2) == 0) : 1;
`else
      return 1;
`endif
   endfunction

   // Reference model: second counting from the game rules, one expectation per edge.
   always @(posedge clk or posedge rst) begin
      exp_t e;
      e.t = 0;
      e.e = 0;
      if (rst) begin
         q.delete();
         m_sec = 0; m_rem = LIMIT; m_pre = 0; m_hold = 0; m_hk = 0;
      end else if (!timer_start) begin
         m_sec = 0; m_rem = LIMIT; m_pre = 0; m_hold = 0;
      end else if (timer_endn) begin
         m_hk = m_hold ? m_hk + 1 : 0;
         m_hold = 1;
      end else begin
         m_hold = 0;
         if (m_pre == CLK_DIV - 1) begin
            m_pre = 0;
            e.t = 1;
            if (m_sec < SEC_MAX) m_sec++;
            if (countdown_en && m_rem > 0) begin
               e.e = (m_rem == 1 && mode) ? 1 : 0;
               m_rem--;
            end
         end else m_pre++;
      end
      e.s = m_sec;
      e.r = m_rem;
      e.b = m_blink();
      q.push_back(e);
      started = 1;
   end

   always @(negedge clk) begin
      if (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         chk("sec", int'(sec), e.s);
         chk("remain", int'(remain), e.r);
         chk("disp_bcd", int'(disp_bcd), to_bcd(mode ? e.r : e.s));
         chk("tick", int'(tick), e.t);
         chk("expire", int'(expire), e.e);
         chk("blink", int'(blink), e.b);
      end else if (started) begin
         chk("scoreboard_empty", 0, 1);
      end
   end

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic set_in(logic s, logic en, logic c, logic m);
      timer_start = s; timer_endn = en; countdown_en = c; mode = m;
   endtask

   initial begin
      #1 rst = 1;
      step(2);
      rst = 0;
      step(1);
      set_in(1, 0, 0, 0);
      step(26);
      set_in(0, 0, 0, 0);
      step(1);
      set_in(1, 0, 1, 1);
      step(34);
      set_in(0, 0, 0, 0);
      step(1);
      set_in(1, 0, 1, 0);
      step(44);
      timer_endn = 1;
      step(40);
      timer_endn = 0;
      step(20);
      set_in(0, 0, 0, 0);
      step(1);
      set_in(1, 0, 0, 0);
      step(7);
      timer_endn = 1;
      step(1);
      timer_endn = 0;
      step(11);
      timer_start = 0;
      step(2);
      set_in(1, 0, 1, 1);
      for (int i = 0; i < 500; i++) begin
         timer_start = ($urandom_range(0, 59) != 0);
         if ($urandom_range(0, 11) == 0) timer_endn = ~timer_endn;
         countdown_en = ($urandom_range(0, 3) != 0);
         mode = $urandom_range(0, 1);
         step(1);
      end
      set_in(0, 0, 0, 0);
      step(1);
      set_in(1, 0, 0, 0);
      step(1002 * CLK_DIV);
      mode = 1;
      step(3);
      mode = 0;
      step(3);
      rst = 1;
      #1;
      chk("async_sec", int'(sec), 0);
      chk("async_remain", int'(remain), LIMIT);
      chk("async_disp", int'(disp_bcd), to_bcd(0));
      chk("async_tick", int'(tick), 0);
      chk("async_expire", int'(expire), 0);
      chk("async_blink", int'(blink), 1);
      step(2);
      rst = 0;
      step(20);
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
